// File: rtl/active_list.sv
// Active list (reorder buffer) for an in-order-retire, out-of-order-complete core.
// Allocates at tail, retires done entries at head, and unwinds squashed entries one per cycle after a mispredict.
module active_list #(
    parameter int DEPTH  = 32,
    parameter int PHYS_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_uses_rw,
    input  logic [4:0]                 alloc_rw_addr,
    input  logic [PHYS_W-1:0]          alloc_new_phys,
    input  logic [PHYS_W-1:0]          alloc_old_phys,
    output logic [$clog2(DEPTH)-1:0]   alloc_index,

    input  logic                       complete_valid,
    input  logic [$clog2(DEPTH)-1:0]   complete_index,
    input  logic                       complete_mispredict,

    output logic                       retire_valid,
    output logic                       retire_uses_rw,
    output logic [4:0]                 retire_rw_addr,
    output logic [PHYS_W-1:0]          retire_old_phys,

    output logic                       rollback_valid,
    output logic                       rollback_uses_rw,
    output logic [4:0]                 rollback_rw_addr,
    output logic [PHYS_W-1:0]          rollback_new_phys,
    output logic [PHYS_W-1:0]          rollback_old_phys,

    output logic                       busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef logic [IW-1:0] idx_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {NORMAL, ROLLBACK} state_t;

    state_t           state_q, state_d;
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    ptr_t             target_q, target_d;
    logic [DEPTH-1:0] done_q, done_d;

    logic              ent_uses_q [DEPTH];
    logic [4:0]        ent_rw_q   [DEPTH];
    logic [PHYS_W-1:0] ent_new_q  [DEPTH];
    logic [PHYS_W-1:0] ent_old_q  [DEPTH];

    ptr_t count;
    ptr_t tail_m1;
    ptr_t cpl_age;
    ptr_t cpl_next;
    ptr_t tgt_age;
    idx_t head_idx;
    idx_t tail_idx;
    idx_t last_idx;
    logic cpl_live;
    logic cpl_older;
    logic alloc_fire;

    assign count    = tail_q - head_q;
    assign tail_m1  = tail_q - PW'(1);
    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign last_idx = tail_m1[IW-1:0];

    // Age relative to head decides liveness, so stale indices beyond tail are ignored.
    assign cpl_age   = PW'(idx_t'(complete_index - head_idx));
    assign cpl_next  = head_q + cpl_age + PW'(1);
    assign tgt_age   = target_q - head_q;
    assign cpl_live  = complete_valid && (cpl_age < count);
    assign cpl_older = complete_valid && (cpl_age < tgt_age);

    assign alloc_ready = !rst && (state_q == NORMAL) && (count < PW'(DEPTH))
                         && !(complete_valid && complete_mispredict);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_index = tail_idx;

    assign retire_valid    = !rst && (state_q == NORMAL) && (count != '0) && done_q[head_idx];
    assign retire_uses_rw  = ent_uses_q[head_idx];
    assign retire_rw_addr  = ent_rw_q[head_idx];
    assign retire_old_phys = ent_old_q[head_idx];

    assign rollback_valid    = !rst && (state_q == ROLLBACK);
    assign rollback_uses_rw  = ent_uses_q[last_idx];
    assign rollback_rw_addr  = ent_rw_q[last_idx];
    assign rollback_new_phys = ent_new_q[last_idx];
    assign rollback_old_phys = ent_old_q[last_idx];

    assign busy = !rst && (state_q == ROLLBACK);

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        target_d = target_q;
        done_d   = done_q;

        if (alloc_fire) begin
            done_d[tail_idx] = 1'b0;
            tail_d           = tail_q + PW'(1);
        end
        if (retire_valid) begin
            head_d = head_q + PW'(1);
        end

        case (state_q)
            NORMAL: begin
                if (cpl_live) begin
                    done_d[complete_index] = 1'b1;
                    if (complete_mispredict) begin
                        target_d = cpl_next;
                        if (cpl_next != tail_q) begin
                            state_d = ROLLBACK;
                        end
                    end
                end
            end
            ROLLBACK: begin
                tail_d = tail_m1;
                if (cpl_older) begin
                    done_d[complete_index] = 1'b1;
                    if (complete_mispredict) begin
                        target_d = cpl_next;
                    end
                end
                // Exit compares against the retargeted value so a late retarget extends this pass.
                if (tail_m1 == target_d) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            head_q   <= '0;
            tail_q   <= '0;
            target_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_uses_q[tail_idx] <= alloc_uses_rw;
            ent_rw_q[tail_idx]   <= alloc_rw_addr;
            ent_new_q[tail_idx]  <= alloc_new_phys;
            ent_old_q[tail_idx]  <= alloc_old_phys;
        end
    end

endmodule

// File: tb/tb_active_list.sv
// Scoreboard bench for active_list: expected retire/rollback payloads are queued as stimulus is driven
// and popped by a negedge monitor; scenario tasks check handshake and timing inline.
module tb_active_list;

    localparam int DEPTH  = 32;
    localparam int PHYS_W = 6;
    localparam int IW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_uses_rw;
    logic [4:0]        alloc_rw_addr;
    logic [PHYS_W-1:0] alloc_new_phys;
    logic [PHYS_W-1:0] alloc_old_phys;
    logic [IW-1:0]     alloc_index;
    logic              complete_valid;
    logic [IW-1:0]     complete_index;
    logic              complete_mispredict;
    logic              retire_valid;
    logic              retire_uses_rw;
    logic [4:0]        retire_rw_addr;
    logic [PHYS_W-1:0] retire_old_phys;
    logic              rollback_valid;
    logic              rollback_uses_rw;
    logic [4:0]        rollback_rw_addr;
    logic [PHYS_W-1:0] rollback_new_phys;
    logic [PHYS_W-1:0] rollback_old_phys;
    logic              busy;

    typedef struct packed {
        logic              uses;
        logic [4:0]        rw;
        logic [PHYS_W-1:0] np;
        logic [PHYS_W-1:0] op;
    } ent_t;

    ent_t model [DEPTH];
    ent_t exp_ret [$];
    ent_t exp_rb [$];
    ent_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   m_tail = 0;

    active_list #(.DEPTH(DEPTH), .PHYS_W(PHYS_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_valid         (alloc_valid),
        .alloc_ready         (alloc_ready),
        .alloc_uses_rw       (alloc_uses_rw),
        .alloc_rw_addr       (alloc_rw_addr),
        .alloc_new_phys      (alloc_new_phys),
        .alloc_old_phys      (alloc_old_phys),
        .alloc_index         (alloc_index),
        .complete_valid      (complete_valid),
        .complete_index      (complete_index),
        .complete_mispredict (complete_mispredict),
        .retire_valid        (retire_valid),
        .retire_uses_rw      (retire_uses_rw),
        .retire_rw_addr      (retire_rw_addr),
        .retire_old_phys     (retire_old_phys),
        .rollback_valid      (rollback_valid),
        .rollback_uses_rw    (rollback_uses_rw),
        .rollback_rw_addr    (rollback_rw_addr),
        .rollback_new_phys   (rollback_new_phys),
        .rollback_old_phys   (rollback_old_phys),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (retire_valid === 1'b1) begin
            total++;
            if (exp_ret.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got rw=%0d old=%0d, want no retire", retire_rw_addr, retire_old_phys);
            end else begin
                mon_e = exp_ret.pop_front();
                if ({retire_uses_rw, retire_rw_addr, retire_old_phys} !== {mon_e.uses, mon_e.rw, mon_e.op}) begin
                    bad++;
                    $display("FAIL retire_payload: got uses=%0d rw=%0d old=%0d, want uses=%0d rw=%0d old=%0d",
                             retire_uses_rw, retire_rw_addr, retire_old_phys, mon_e.uses, mon_e.rw, mon_e.op);
                end
            end
        end
        if (rollback_valid === 1'b1) begin
            total++;
            if (exp_rb.size() == 0) begin
                bad++;
                $display("FAIL rollback_unexpected: got rw=%0d new=%0d, want no rollback", rollback_rw_addr, rollback_new_phys);
            end else begin
                mon_e = exp_rb.pop_front();
                if ({rollback_uses_rw, rollback_rw_addr, rollback_new_phys, rollback_old_phys}
                    !== {mon_e.uses, mon_e.rw, mon_e.np, mon_e.op}) begin
                    bad++;
                    $display("FAIL rollback_payload: got uses=%0d rw=%0d new=%0d old=%0d, want uses=%0d rw=%0d new=%0d old=%0d",
                             rollback_uses_rw, rollback_rw_addr, rollback_new_phys, rollback_old_phys,
                             mon_e.uses, mon_e.rw, mon_e.np, mon_e.op);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid         = 1'b0;
        complete_valid      = 1'b0;
        complete_mispredict = 1'b0;
    endtask

    task automatic set_alloc(input logic u, input logic [4:0] rw, input logic [PHYS_W-1:0] np, input logic [PHYS_W-1:0] op);
        alloc_valid    = 1'b1;
        alloc_uses_rw  = u;
        alloc_rw_addr  = rw;
        alloc_new_phys = np;
        alloc_old_phys = op;
        model[m_tail % DEPTH] = {u, rw, np, op};
        m_tail++;
    endtask

    task automatic do_alloc(input logic u, input logic [4:0] rw, input logic [PHYS_W-1:0] np, input logic [PHYS_W-1:0] op);
        set_alloc(u, rw, np, op);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_cpl(input int idx, input logic mis);
        complete_valid      = 1'b1;
        complete_index      = idx[IW-1:0];
        complete_mispredict = mis;
    endtask

    task automatic do_cpl(input int idx, input logic mis);
        set_cpl(idx, mis);
        tick();
        complete_valid      = 1'b0;
        complete_mispredict = 1'b0;
    endtask

    task automatic push_ret(input int idx);
        exp_ret.push_back(model[idx % DEPTH]);
    endtask

    task automatic push_rb(input int idx);
        exp_rb.push_back(model[idx % DEPTH]);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        m_tail = 0;
        exp_ret.delete();
        exp_rb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        alloc_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({alloc_ready, retire_valid, rollback_valid, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got ready/ret/rb/busy=%b, want 0000", {alloc_ready, retire_valid, rollback_valid, busy});
        end
        tick();
        rst = 1'b0;
        alloc_valid = 1'b0;
        m_tail = 0;
        @(negedge clk);
        total++;
        if ({alloc_ready, retire_valid, busy} !== 3'b100 || alloc_index !== 5'd0) begin
            bad++;
            $display("FAIL reset_release: got ready/ret/busy=%b idx=%0d, want 100 idx=0", {alloc_ready, retire_valid, busy}, alloc_index);
        end
        tick();
    endtask

    task automatic test_retire_order();
        apply_reset();
        for (int i = 0; i < 3; i++) do_alloc(1'b1, 5'(i + 1), 6'(40 + i), 6'(10 + i));
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL ro_none_done: got retire_valid=%b, want 0", retire_valid); end
        tick();
        push_ret(0);
        push_ret(1);
        set_cpl(1, 1'b0);
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL ro_cpl1: got retire_valid=%b, want 0", retire_valid); end
        tick();
        set_cpl(0, 1'b0);
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL ro_same_cycle: got retire_valid=%b, want 0", retire_valid); end
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (retire_valid !== 1'b1 || retire_rw_addr !== 5'(k + 1)) begin
                bad++;
                $display("FAIL ro_retire%0d: got valid=%b rw=%0d, want valid=1 rw=%0d", k, retire_valid, retire_rw_addr, k + 1);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (retire_valid !== 1'b0) begin bad++; $display("FAIL ro_hold2: got retire_valid=%b, want 0", retire_valid); end
            tick();
        end
        push_ret(2);
        do_cpl(2, 1'b0);
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b1 || retire_new_ok(retire_rw_addr) !== 1'b1) begin
            bad++;
            $display("FAIL ro_retire2: got valid=%b rw=%0d, want valid=1 rw=3", retire_valid, retire_rw_addr);
        end
        tick();
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL ro_empty: got retire_valid=%b, want 0", retire_valid); end
        tick();
        total++;
        if (exp_ret.size() != 0) begin bad++; $display("FAIL ro_drained: got %0d pending retires, want 0", exp_ret.size()); end
    endtask

    function automatic logic retire_new_ok(input logic [4:0] rw);
        return rw == 5'd3;
    endfunction

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(i[0], 5'(i), 6'(i), 6'(63 - i));
            @(negedge clk);
            total++;
            if (alloc_ready !== 1'b1 || alloc_index !== 5'(i)) begin
                bad++;
                $display("FAIL fw_fill: got ready=%b idx=%0d, want ready=1 idx=%0d", alloc_ready, alloc_index, i);
            end
            tick();
            alloc_valid = 1'b0;
        end
        alloc_valid = 1'b1;
        @(negedge clk);
        total++;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fw_full: got alloc_ready=%b, want 0", alloc_ready); end
        tick();
        push_ret(0);
        set_cpl(0, 1'b0);
        @(negedge clk);
        total++;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fw_full_cpl: got alloc_ready=%b, want 0", alloc_ready); end
        tick();
        complete_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({retire_valid, alloc_ready} !== 2'b10) begin
            bad++;
            $display("FAIL fw_retire_full: got retire_valid/alloc_ready=%b, want 10", {retire_valid, alloc_ready});
        end
        tick();
        alloc_valid = 1'b0;
        @(negedge clk);
        total++;
        if (alloc_ready !== 1'b1 || alloc_index !== 5'd0) begin
            bad++;
            $display("FAIL fw_wrap: got ready=%b idx=%0d, want ready=1 idx=0", alloc_ready, alloc_index);
        end
        tick();
        do_alloc(1'b1, 5'd7, 6'd33, 6'd44);
        @(negedge clk);
        total++;
        if (alloc_ready !== 1'b0 || alloc_index !== 5'd1) begin
            bad++;
            $display("FAIL fw_full_again: got ready=%b idx=%0d, want ready=0 idx=1", alloc_ready, alloc_index);
        end
        tick();
        total++;
        if (exp_ret.size() != 0) begin bad++; $display("FAIL fw_drained: got %0d pending retires, want 0", exp_ret.size()); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_alloc(1'b1, 5'd11, 6'd1, 6'd21);
        do_alloc(1'b0, 5'd12, 6'd2, 6'd22);
        push_ret(0);
        push_ret(1);
        do_cpl(0, 1'b0);
        set_alloc(1'b1, 5'd13, 6'd3, 6'd23);
        set_cpl(1, 1'b0);
        @(negedge clk);
        total++;
        if ({retire_valid, alloc_ready} !== 2'b11 || alloc_index !== 5'd2) begin
            bad++;
            $display("FAIL b2b_first: got ret/ready=%b idx=%0d, want 11 idx=2", {retire_valid, alloc_ready}, alloc_index);
        end
        tick();
        idle();
        set_alloc(1'b1, 5'd14, 6'd4, 6'd24);
        @(negedge clk);
        total++;
        if ({retire_valid, alloc_ready} !== 2'b11 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL b2b_second: got ret/ready=%b idx=%0d, want 11 idx=3", {retire_valid, alloc_ready}, alloc_index);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0 || alloc_index !== 5'd4) begin
            bad++;
            $display("FAIL b2b_count: got ret=%b idx=%0d, want ret=0 idx=4", retire_valid, alloc_index);
        end
        tick();
        push_ret(2);
        push_ret(3);
        do_cpl(3, 1'b0);
        do_cpl(2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (retire_valid !== 1'b1) begin bad++; $display("FAIL b2b_drain: got retire_valid=%b, want 1", retire_valid); end
            tick();
        end
        total++;
        if (exp_ret.size() != 0) begin bad++; $display("FAIL b2b_drained: got %0d pending retires, want 0", exp_ret.size()); end
    endtask

    task automatic test_rollback();
        apply_reset();
        for (int i = 0; i < 6; i++) do_alloc(i[0], 5'(i + 1), 6'(20 + i), 6'(50 + i));
        push_rb(5);
        push_rb(4);
        push_rb(3);
        set_cpl(2, 1'b1);
        @(negedge clk);
        total++;
        if ({alloc_ready, busy} !== 2'b00) begin
            bad++;
            $display("FAIL rb_mis_cycle: got ready/busy=%b, want 00", {alloc_ready, busy});
        end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({busy, rollback_valid, retire_valid, alloc_ready} !== 4'b1100) begin
                bad++;
                $display("FAIL rb_busy%0d: got busy/rb/ret/ready=%b, want 1100", k, {busy, rollback_valid, retire_valid, alloc_ready});
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({busy, rollback_valid, alloc_ready} !== 3'b001 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL rb_done: got busy/rb/ready=%b idx=%0d, want 001 idx=3", {busy, rollback_valid, alloc_ready}, alloc_index);
        end
        tick();
        m_tail = 3;
        push_ret(0);
        push_ret(1);
        push_ret(2);
        do_cpl(0, 1'b0);
        do_cpl(1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (retire_valid !== 1'b1) begin bad++; $display("FAIL rb_retire%0d: got retire_valid=%b, want 1", k + 1, retire_valid); end
            tick();
        end
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL rb_empty: got retire_valid=%b, want 0", retire_valid); end
        tick();
        total++;
        if (exp_ret.size() != 0 || exp_rb.size() != 0) begin
            bad++;
            $display("FAIL rb_drained: got ret=%0d rb=%0d pending, want 0 0", exp_ret.size(), exp_rb.size());
        end
    endtask

    task automatic test_retarget();
        int nb;
        apply_reset();
        for (int i = 0; i < 8; i++) do_alloc(~i[0], 5'(i + 3), 6'(30 + i), 6'(i));
        for (int i = 7; i >= 3; i--) push_rb(i);
        push_ret(0);
        do_cpl(3, 1'b1);
        set_cpl(2, 1'b1);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rt_w1: got busy=%b, want 1", busy); end
        tick();
        idle();
        set_cpl(5, 1'b1);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rt_w2: got busy=%b, want 1", busy); end
        tick();
        idle();
        set_cpl(0, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rt_w3: got busy=%b, want 1", busy); end
        tick();
        idle();
        nb = 3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            nb++;
            tick();
        end
        total++;
        if (nb != 5) begin bad++; $display("FAIL rt_cycles: got %0d busy cycles, want 5", nb); end
        total++;
        if (rollback_valid !== 1'b0 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL rt_tail: got rb=%b idx=%0d, want rb=0 idx=3", rollback_valid, alloc_index);
        end
        tick();
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL rt_head1: got retire_valid=%b, want 0", retire_valid); end
        tick();
        m_tail = 3;
        total++;
        if (exp_ret.size() != 0 || exp_rb.size() != 0) begin
            bad++;
            $display("FAIL rt_drained: got ret=%0d rb=%0d pending, want 0 0", exp_ret.size(), exp_rb.size());
        end
    endtask

    task automatic test_ignore();
        apply_reset();
        for (int i = 0; i < 3; i++) do_alloc(1'b1, 5'(i + 20), 6'(i + 1), 6'(i + 60));
        do_cpl(3, 1'b0);
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL ig_nonlive: got ret=%b idx=%0d, want ret=0 idx=3", retire_valid, alloc_index);
        end
        tick();
        do_cpl(9, 1'b1);
        @(negedge clk);
        total++;
        if ({busy, rollback_valid} !== 2'b00 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL ig_nonlive_mis: got busy/rb=%b idx=%0d, want 00 idx=3", {busy, rollback_valid}, alloc_index);
        end
        tick();
        set_cpl(2, 1'b1);
        @(negedge clk);
        total++;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL ig_mis_block: got alloc_ready=%b, want 0", alloc_ready); end
        tick();
        idle();
        @(negedge clk);
        total++;
        if ({busy, rollback_valid, alloc_ready} !== 3'b001 || alloc_index !== 5'd3) begin
            bad++;
            $display("FAIL ig_youngest: got busy/rb/ready=%b idx=%0d, want 001 idx=3", {busy, rollback_valid, alloc_ready}, alloc_index);
        end
        tick();
        do_alloc(1'b1, 5'd30, 6'd9, 6'd19);
        push_ret(0);
        push_ret(1);
        push_ret(2);
        do_cpl(0, 1'b0);
        do_cpl(1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (retire_valid !== 1'b1) begin bad++; $display("FAIL ig_retire%0d: got retire_valid=%b, want 1", k + 1, retire_valid); end
            tick();
        end
        @(negedge clk);
        total++;
        if (retire_valid !== 1'b0) begin bad++; $display("FAIL ig_entry3_held: got retire_valid=%b, want 0", retire_valid); end
        tick();
        total++;
        if (exp_ret.size() != 0) begin bad++; $display("FAIL ig_drained: got %0d pending retires, want 0", exp_ret.size()); end
    endtask

    task automatic test_reset_rollback();
        apply_reset();
        for (int i = 0; i < 6; i++) do_alloc(1'b1, 5'(i + 8), 6'(i + 10), 6'(i + 30));
        push_rb(5);
        do_cpl(0, 1'b1);
        @(negedge clk);
        total++;
        if ({busy, rollback_valid} !== 2'b11) begin
            bad++;
            $display("FAIL rr_active: got busy/rb=%b, want 11", {busy, rollback_valid});
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rollback_valid, busy, alloc_ready, retire_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL rr_in_reset: got rb/busy/ready/ret=%b, want 0000", {rollback_valid, busy, alloc_ready, retire_valid});
        end
        tick();
        rst = 1'b0;
        m_tail = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({rollback_valid, busy, alloc_ready, retire_valid} !== 4'b0010 || alloc_index !== 5'd0) begin
                bad++;
                $display("FAIL rr_after%0d: got rb/busy/ready/ret=%b idx=%0d, want 0010 idx=0",
                         k, {rollback_valid, busy, alloc_ready, retire_valid}, alloc_index);
            end
            tick();
        end
        total++;
        if (exp_rb.size() != 0) begin bad++; $display("FAIL rr_drained: got %0d pending rollbacks, want 0", exp_rb.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        idle();
        alloc_uses_rw  = 1'b0;
        alloc_rw_addr  = '0;
        alloc_new_phys = '0;
        alloc_old_phys = '0;
        complete_index = '0;
        test_reset();
        test_retire_order();
        test_full_wrap();
        test_back_to_back();
        test_rollback();
        test_retarget();
        test_ignore();
        test_reset_rollback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
